// File: rtl/jump_link_unit.sv
// Multi-lane jump/link resolver: picks the oldest jump, registers redirect and link, masks a wrong-path shadow.
// Optional return-address stack is built when JLU_RAS_EN is defined.

module jump_link_lane #(
    parameter int PC_WIDTH   = 32,
    parameter int JUMP_WIDTH = 26
) (
    input  logic [1:0]            op,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [JUMP_WIDTH-1:0] jaddr,
    input  logic [PC_WIDTH-1:0]   rs_val,
    output logic [PC_WIDTH-1:0]   target,
    output logic [PC_WIDTH-1:0]   link,
    output logic                  misalign
);
    always_comb begin
        target = pc;
        target[JUMP_WIDTH+1:0] = {jaddr, 2'b00};
        if (op[1]) target = rs_val;
    end

    assign link     = pc + PC_WIDTH'(4);
    assign misalign = op[1] & (|rs_val[1:0]);
endmodule

module jump_link_unit #(
    parameter int PC_WIDTH      = 32,
    parameter int JUMP_WIDTH    = 26,
    parameter int LANES         = 2,
    parameter int LANE_W        = 1,
    parameter int SHADOW_CYCLES = 1,
    parameter int RAS_DEPTH     = 8
) (
    input  logic                        jl_i_clk,
    input  logic                        jl_i_rst,
    input  logic [LANES-1:0]            jl_i_valid,
    input  logic [2*LANES-1:0]          jl_i_op,
    input  logic [PC_WIDTH*LANES-1:0]   jl_i_pc,
    input  logic [JUMP_WIDTH*LANES-1:0] jl_i_jaddr,
    input  logic [PC_WIDTH*LANES-1:0]   jl_i_rs_val,
    input  logic [LANES-1:0]            jl_i_rs_is_ra,
    input  logic                        jl_i_stall,
    input  logic                        jl_i_flush,
    output logic                        jl_o_change_pc,
    output logic [PC_WIDTH-1:0]         jl_o_pc,
    output logic [PC_WIDTH-1:0]         jl_o_ra,
    output logic                        jl_o_link_we,
    output logic [LANE_W-1:0]           jl_o_lane,
    output logic [LANES-1:0]            jl_o_squash,
    output logic                        jl_o_misalign,
    output logic                        jl_o_busy,
    output logic                        jl_o_ras_miss,
    output logic [PC_WIDTH-1:0]         jl_o_ras_top
);
    localparam int CNT_W = 3;

    typedef enum logic {IDLE = 1'b0, SHADOW = 1'b1} state_t;

    logic [LANES-1:0][1:0]          op_arr;
    logic [LANES-1:0][PC_WIDTH-1:0] lane_target;
    logic [LANES-1:0][PC_WIDTH-1:0] lane_link;
    logic [LANES-1:0]               lane_misalign;

    assign op_arr = jl_i_op;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        jump_link_lane #(
            .PC_WIDTH  (PC_WIDTH),
            .JUMP_WIDTH(JUMP_WIDTH)
        ) u_lane (
            .op      (op_arr[k]),
            .pc      (jl_i_pc[k*PC_WIDTH +: PC_WIDTH]),
            .jaddr   (jl_i_jaddr[k*JUMP_WIDTH +: JUMP_WIDTH]),
            .rs_val  (jl_i_rs_val[k*PC_WIDTH +: PC_WIDTH]),
            .target  (lane_target[k]),
            .link    (lane_link[k]),
            .misalign(lane_misalign[k])
        );
    end

    // Oldest lane wins: scan from the youngest so the lowest index overrides.
    logic [LANE_W-1:0] win_lane;
    logic [1:0]        win_op;
    logic              accept;
    state_t            state_q, state_d;

    always_comb begin
        win_lane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (jl_i_valid[k]) win_lane = LANE_W'(k);
        end
    end

    assign win_op = op_arr[win_lane];
    assign accept = (|jl_i_valid) && (state_q == IDLE) && !jl_i_stall && !jl_i_flush;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                change_pc_q, change_pc_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] ra_q, ra_d;
    logic                link_we_q, link_we_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [LANES-1:0]    squash_q, squash_d;
    logic                misalign_q, misalign_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        change_pc_d = accept;
        link_we_d   = accept & win_op[0];
        misalign_d  = accept & lane_misalign[win_lane];
        pc_d        = accept ? lane_target[win_lane] : pc_q;
        ra_d        = accept ? lane_link[win_lane] : ra_q;
        lane_d      = accept ? win_lane : lane_q;
        // busy reports the shadow cycle just consumed, so it trails the input mask by one cycle.
        busy_d      = (state_q == SHADOW) && !jl_i_flush;
        for (int k = 0; k < LANES; k++) begin
            squash_d[k] = accept && (k > int'(win_lane));
        end

        case (state_q)
            IDLE: begin
                if (accept && SHADOW_CYCLES > 0) begin
                    state_d = SHADOW;
                    cnt_d   = CNT_W'(SHADOW_CYCLES);
                end
            end
            SHADOW: begin
                if (jl_i_flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!jl_i_stall) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge jl_i_clk) begin
        if (jl_i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            change_pc_q <= 1'b0;
            pc_q        <= '0;
            ra_q        <= '0;
            link_we_q   <= 1'b0;
            lane_q      <= '0;
            squash_q    <= '0;
            misalign_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            change_pc_q <= change_pc_d;
            pc_q        <= pc_d;
            ra_q        <= ra_d;
            link_we_q   <= link_we_d;
            lane_q      <= lane_d;
            squash_q    <= squash_d;
            misalign_q  <= misalign_d;
            busy_q      <= busy_d;
        end
    end

    assign jl_o_change_pc = change_pc_q;
    assign jl_o_pc        = pc_q;
    assign jl_o_ra        = ra_q;
    assign jl_o_link_we   = link_we_q;
    assign jl_o_lane      = lane_q;
    assign jl_o_squash    = squash_q;
    assign jl_o_misalign  = misalign_q;
    assign jl_o_busy      = busy_q;

`ifdef JLU_RAS_EN
    localparam int RAS_AW = $clog2(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [RAS_AW-1:0]   ras_ptr_q, ras_ptr_d;
    logic [RAS_AW:0]     ras_cnt_q, ras_cnt_d;
    logic                ras_miss_q, ras_miss_d;
    logic [PC_WIDTH-1:0] ras_top_q, ras_top_d;
    logic                ras_we;
    logic [RAS_AW-1:0]   ras_widx, ras_pop_idx, ras_rd_idx;
    logic [PC_WIDTH-1:0] ras_wdata;
    logic                do_pop, do_push;

    // ras_ptr_q is the next write slot; the top lives one below it.
    always_comb begin
        do_push     = accept && win_op[0];
        do_pop      = accept && win_op[1] && jl_i_rs_is_ra[win_lane];
        ras_ptr_d   = ras_ptr_q;
        ras_cnt_d   = ras_cnt_q;
        ras_miss_d  = 1'b0;
        ras_we      = 1'b0;
        ras_widx    = ras_ptr_q;
        ras_wdata   = lane_link[win_lane];
        ras_pop_idx = ras_ptr_q - RAS_AW'(1);

        if (do_pop) begin
            if (ras_cnt_q == '0) begin
                ras_miss_d = 1'b1;
            end else begin
                // JR/JALR target is the unmodified rs value.
                ras_miss_d = (ras_mem_q[ras_pop_idx] != lane_target[win_lane]);
                ras_ptr_d  = ras_pop_idx;
                ras_cnt_d  = ras_cnt_q - (RAS_AW+1)'(1);
            end
        end
        if (do_push) begin
            ras_we    = 1'b1;
            ras_widx  = ras_ptr_d;
            ras_ptr_d = ras_ptr_d + RAS_AW'(1);
            if (ras_cnt_d != (RAS_AW+1)'(RAS_DEPTH)) ras_cnt_d = ras_cnt_d + (RAS_AW+1)'(1);
        end

        ras_rd_idx = ras_ptr_d - RAS_AW'(1);
        if (ras_cnt_d == '0)  ras_top_d = '0;
        else if (ras_we)      ras_top_d = ras_wdata;
        else                  ras_top_d = ras_mem_q[ras_rd_idx];
    end

    always_ff @(posedge jl_i_clk) begin
        if (jl_i_rst) begin
            ras_ptr_q  <= '0;
            ras_cnt_q  <= '0;
            ras_miss_q <= 1'b0;
            ras_top_q  <= '0;
        end else begin
            ras_ptr_q  <= ras_ptr_d;
            ras_cnt_q  <= ras_cnt_d;
            ras_miss_q <= ras_miss_d;
            ras_top_q  <= ras_top_d;
            if (ras_we) ras_mem_q[ras_widx] <= ras_wdata;
        end
    end

    assign jl_o_ras_miss = ras_miss_q;
    assign jl_o_ras_top  = ras_top_q;
`else
    logic unused_ras;
    assign unused_ras    = (^jl_i_rs_is_ra) ^ (RAS_DEPTH > 0);
    assign jl_o_ras_miss = 1'b0;
    assign jl_o_ras_top  = '0;
`endif
endmodule

// File: tb/tb_jump_link_unit.sv
// Bench for jump_link_unit: directed vector table, hand sequences, randomized run against a reference model.
module tb_jump_link_unit;
    localparam int PW = 32;
    localparam int JW = 26;
    localparam int L  = 2;
    localparam int SC = 1;
    localparam int RD = 2;

    logic          clk = 1'b0;
    logic          rst, stall, flush;
    logic [L-1:0]  valid, isra;
    logic [2*L-1:0] op;
    logic [PW*L-1:0] pc_i, rs;
    logic [JW*L-1:0] ja;
    logic          change, we, mis, busy, rmiss;
    logic [PW-1:0] opc, ora, rtop;
    logic [0:0]    lane;
    logic [L-1:0]  squash;

    jump_link_unit #(.PC_WIDTH(PW), .JUMP_WIDTH(JW), .LANES(L), .LANE_W(1),
                     .SHADOW_CYCLES(SC), .RAS_DEPTH(RD)) dut (
        .jl_i_clk(clk), .jl_i_rst(rst), .jl_i_valid(valid), .jl_i_op(op),
        .jl_i_pc(pc_i), .jl_i_jaddr(ja), .jl_i_rs_val(rs), .jl_i_rs_is_ra(isra),
        .jl_i_stall(stall), .jl_i_flush(flush),
        .jl_o_change_pc(change), .jl_o_pc(opc), .jl_o_ra(ora), .jl_o_link_we(we),
        .jl_o_lane(lane), .jl_o_squash(squash), .jl_o_misalign(mis), .jl_o_busy(busy),
        .jl_o_ras_miss(rmiss), .jl_o_ras_top(rtop)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic          m_change, m_we, m_mis, m_busy, m_rmiss;
    logic [PW-1:0] m_pc, m_ra, m_rtop;
    int            m_lane, m_left;
    logic [L-1:0]  m_squash;
    logic [PW-1:0] ras_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int w;
        logic [1:0]    lop;
        logic [PW-1:0] lpc, lrs, lja;
        if (rst) begin
            m_change = 0; m_we = 0; m_mis = 0; m_busy = 0; m_rmiss = 0;
            m_pc = 0; m_ra = 0; m_rtop = 0; m_lane = 0; m_squash = 0; m_left = 0;
            ras_q.delete();
            return;
        end
        m_busy = (m_left > 0) && !flush;
        m_change = 0; m_we = 0; m_mis = 0; m_squash = 0; m_rmiss = 0;
        w = -1;
        for (int k = 0; k < L; k++) if (valid[k] && w < 0) w = k;
        if (m_left == 0 && !stall && !flush && w >= 0) begin
            lop = op[2*w +: 2];
            lpc = pc_i[PW*w +: PW];
            lrs = rs[PW*w +: PW];
            lja = PW'(ja[JW*w +: JW]);
            m_change = 1;
            m_lane   = w;
            m_ra     = lpc + 32'd4;
            m_we     = lop[0];
            m_pc     = lop[1] ? lrs : (lpc / 32'h1000_0000) * 32'h1000_0000 + lja * 4;
            m_mis    = lop[1] && (lrs % 4 != 0);
            for (int k = w + 1; k < L; k++) m_squash[k] = 1'b1;
            m_left   = SC;
`ifdef JLU_RAS_EN
            if (lop[1] && isra[w]) begin
                if (ras_q.size() == 0) m_rmiss = 1;
                else begin
                    m_rmiss = (ras_q[$] != lrs);
                    void'(ras_q.pop_back());
                end
            end
            if (lop[0]) begin
                ras_q.push_back(lpc + 32'd4);
                if (ras_q.size() > RD) void'(ras_q.pop_front());
            end
            m_rtop = (ras_q.size() > 0) ? ras_q[$] : '0;
`endif
        end else begin
            if (flush) m_left = 0;
            else if (!stall && m_left > 0) m_left--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".change_pc"}, 32'(change), 32'(m_change));
        chk({tag, ".pc"}, opc, m_pc);
        chk({tag, ".ra"}, ora, m_ra);
        chk({tag, ".link_we"}, 32'(we), 32'(m_we));
        chk({tag, ".lane"}, 32'(lane), 32'(m_lane));
        chk({tag, ".squash"}, 32'(squash), 32'(m_squash));
        chk({tag, ".misalign"}, 32'(mis), 32'(m_mis));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".ras_miss"}, 32'(rmiss), 32'(m_rmiss));
        chk({tag, ".ras_top"}, rtop, m_rtop);
    endtask

    typedef struct {
        logic [L-1:0]    valid;
        logic [2*L-1:0]  op;
        logic [PW*L-1:0] pc;
        logic [JW*L-1:0] ja;
        logic [PW*L-1:0] rs;
        logic [PW-1:0]   e_pc, e_ra;
        logic            e_lane, e_mis, e_we;
        logic [L-1:0]    e_sq;
    } vec_t;

    vec_t vt[6];

    initial begin
        rst = 1; stall = 0; flush = 0; valid = 0; isra = 0; op = 0; pc_i = 0; ja = 0; rs = 0;

        // J lane0 upper PC bits kept
        vt[0] = '{2'b01, 4'b0000, {32'h0, 32'h4000_0010}, {26'h0, 26'h0000100}, '0,
                  32'h4000_0400, 32'h4000_0014, 1'b0, 1'b0, 1'b0, 2'b10};
        // lane0 idle, lane1 JAL
        vt[1] = '{2'b10, 4'b0100, {32'h0000_1000, 32'h0}, {26'h0000040, 26'h0}, '0,
                  32'h0000_0100, 32'h0000_1004, 1'b1, 1'b0, 1'b1, 2'b00};
        // lane0 JR misaligned, lane1 J squashed
        vt[2] = '{2'b11, 4'b0010, {32'h0000_7000, 32'h0000_3000}, {26'h1, 26'h0}, {32'h0, 32'h0000_2002},
                  32'h0000_2002, 32'h0000_3004, 1'b0, 1'b1, 1'b0, 2'b10};
        // JALR at all-ones PC: link wraps to 3
        vt[3] = '{2'b01, 4'b0011, {32'h0, 32'hFFFF_FFFF}, '0, {32'h0, 32'h1234_5678},
                  32'h1234_5678, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 2'b10};
        // J with maximum immediate
        vt[4] = '{2'b01, 4'b0000, {32'h0, 32'hABCD_EF00}, {26'h0, 26'h3FF_FFFF}, '0,
                  32'hAFFF_FFFC, 32'hABCD_EF04, 1'b0, 1'b0, 1'b0, 2'b10};
        // lane1 JALR misaligned by one
        vt[5] = '{2'b10, 4'b1100, {32'h0000_0FFC, 32'h0}, '0, {32'h0000_0001, 32'h0},
                  32'h0000_0001, 32'h0000_1000, 1'b1, 1'b1, 1'b1, 2'b00};

        // Reset with a jump presented: everything stays 0
        valid = 2'b01; op = 4'b0001; pc_i = {32'h0, 32'h0000_0100};
        tick(); tick();
        check_model("reset");
        chk("reset.change_pc", 32'(change), 32'd0);
        chk("reset.pc", opc, 32'd0);
        rst = 0; valid = 0;
        tick();

        for (int i = 0; i < 6; i++) begin
            valid = vt[i].valid; op = vt[i].op; pc_i = vt[i].pc; ja = vt[i].ja; rs = vt[i].rs;
            tick();
            valid = 0;
            chk($sformatf("vec%0d.change_pc", i), 32'(change), 32'd1);
            chk($sformatf("vec%0d.pc", i), opc, vt[i].e_pc);
            chk($sformatf("vec%0d.ra", i), ora, vt[i].e_ra);
            chk($sformatf("vec%0d.lane", i), 32'(lane), 32'(vt[i].e_lane));
            chk($sformatf("vec%0d.squash", i), 32'(squash), 32'(vt[i].e_sq));
            chk($sformatf("vec%0d.misalign", i), 32'(mis), 32'(vt[i].e_mis));
            chk($sformatf("vec%0d.link_we", i), 32'(we), 32'(vt[i].e_we));
            tick();
            chk($sformatf("vec%0d.pulse_drop", i), 32'({change, we, mis, squash}), 32'd0);
            chk($sformatf("vec%0d.pc_hold", i), opc, vt[i].e_pc);
            tick();
        end

        // Shadow: valid J held every cycle; pulses on N+1 and N+3 only
        valid = 2'b01; op = 4'b0000; pc_i = {32'h0, 32'h0000_0000}; ja = {26'h0, 26'h10};
        tick(); chk("shadow.n1_change", 32'(change), 32'd1);
        tick(); chk("shadow.n2_change", 32'(change), 32'd0);
                chk("shadow.n2_busy", 32'(busy), 32'd1);
        tick(); chk("shadow.n3_change", 32'(change), 32'd1);
        tick(); chk("shadow.n4_change", 32'(change), 32'd0);
        valid = 0; tick(); tick();

        // Stall: no capture, held values hold; then release captures
        valid = 2'b01; op = 4'b0001; pc_i = {32'h0, 32'h0000_5000}; ja = {26'h0, 26'h20}; stall = 1;
        tick();
        chk("stall.change_pc", 32'(change), 32'd0);
        chk("stall.pc_hold", opc, 32'h0000_0040);
        chk("stall.link_we", 32'(we), 32'd0);
        stall = 0;
        tick();
        chk("stall.release_pc", opc, 32'h0000_0080);
        chk("stall.release_ra", ora, 32'h0000_5004);
        valid = 0; tick(); tick();

        // Flush beats a valid JAL
        valid = 2'b01; flush = 1;
        tick();
        chk("flush.change_pc", 32'(change), 32'd0);
        chk("flush.link_we", 32'(we), 32'd0);
        chk("flush.pc_hold", opc, 32'h0000_0080);
        flush = 0; valid = 0; tick();

`ifdef JLU_RAS_EN
        // Depth-2 stack: three pushes keep B,C; pops of C,B hit, pop of A finds it empty
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            valid = 2'b01; op = 4'b0001; pc_i = {32'h0, 32'h0000_1000 + 32'(i) * 32'h100};
            tick(); valid = 0; tick(); tick();
        end
        for (int i = 0; i < 3; i++) begin
            valid = 2'b01; op = 4'b0010; isra = 2'b01;
            rs = {32'h0, 32'h0000_1204 - 32'(i) * 32'h100};
            tick();
            chk($sformatf("ras.pop%0d_miss", i), 32'(rmiss), (i == 2) ? 32'd1 : 32'd0);
            valid = 0; isra = 0; tick(); tick();
        end
`endif

        // Randomized run against the model
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            valid = L'($urandom_range(0, 3));
            op    = 2*L'($urandom);
            isra  = L'($urandom);
            for (int k = 0; k < L; k++) begin
                pc_i[PW*k +: PW] = $urandom;
                ja[JW*k +: JW]   = JW'($urandom);
                if (ras_q.size() > 0 && $urandom_range(0, 1) == 1) rs[PW*k +: PW] = ras_q[$];
                else rs[PW*k +: PW] = $urandom;
            end
            tick();
            check_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
